// File: rtl/score_ctrl_if.sv
// Score controller bus: round start, per-player score request/grant handshake,
// and the score/winner/status outputs consumed by the display and game logic.
interface score_ctrl_if;
  logic       start;
  logic       hit_a;
  logic       hit_b;
  logic       ack_a;
  logic       ack_b;
  logic [7:0] score_a;
  logic [7:0] score_b;
  logic [1:0] winner;
  logic       busy;
  logic       done;

  modport master (
    output start, hit_a, hit_b,
    input  ack_a, ack_b, score_a, score_b, winner, busy, done
  );

  modport slave (
    input  start, hit_a, hit_b,
    output ack_a, ack_b, score_a, score_b, winner, busy, done
  );
endinterface

// File: rtl/score_ctrl.sv
// Two-player score controller: round-robin grant of score requests, packed-BCD
// score increment, round sequencing. SCORE_CTRL_DEUCE_EN enables the lead-of-two win rule.
//
// state | meaning
// IDLE  | after reset, waiting for start
// PLAY  | round running, arbitrating hit_a / hit_b
// ADD   | one-cycle grant; granted score increments on exit
// WIN   | round over, scores frozen until start
module score_ctrl #(
  parameter int WIN_SCORE = 21
) (
  input  logic      clk,
  input  logic      rst,
  score_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PLAY, ADD, WIN} state_t;

  localparam logic [6:0] WIN_VAL = 7'(WIN_SCORE);

  state_t     state, state_nx;
  logic       prio_b, prio_b_nx;
  logic       gnt_b, gnt_b_nx;
  logic       ack_a_nx, ack_b_nx;
  logic [7:0] score_a_nx, score_b_nx;
  logic [1:0] winner_nx;
  logic [7:0] cur, inc;
  logic       win_hit;
`ifdef SCORE_CTRL_DEUCE_EN
  logic [7:0] opp;
`endif

  // Saturates at 99 so the score register can never leave valid BCD.
  function automatic logic [7:0] bcd_inc(input logic [7:0] s);
    if (s == 8'h99)
      return s;
    if (s[3:0] == 4'd9)
      return {s[7:4] + 4'd1, 4'd0};
    return {s[7:4], s[3:0] + 4'd1};
  endfunction

  function automatic logic [6:0] bcd_val(input logic [7:0] s);
    return 7'(s[7:4]) * 7'd10 + 7'(s[3:0]);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      prio_b      <= 1'b0;
      gnt_b       <= 1'b0;
      bus.ack_a   <= 1'b0;
      bus.ack_b   <= 1'b0;
      bus.score_a <= 8'h00;
      bus.score_b <= 8'h00;
      bus.winner  <= 2'b00;
    end else begin
      state       <= state_nx;
      prio_b      <= prio_b_nx;
      gnt_b       <= gnt_b_nx;
      bus.ack_a   <= ack_a_nx;
      bus.ack_b   <= ack_b_nx;
      bus.score_a <= score_a_nx;
      bus.score_b <= score_b_nx;
      bus.winner  <= winner_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    prio_b_nx  = prio_b;
    gnt_b_nx   = gnt_b;
    ack_a_nx   = 1'b0;
    ack_b_nx   = 1'b0;
    score_a_nx = bus.score_a;
    score_b_nx = bus.score_b;
    winner_nx  = bus.winner;

    cur = gnt_b ? bus.score_b : bus.score_a;
    inc = bcd_inc(cur);
`ifdef SCORE_CTRL_DEUCE_EN
    opp     = gnt_b ? bus.score_a : bus.score_b;
    win_hit = (cur == 8'h99) ||
              ((bcd_val(inc) >= WIN_VAL) && (bcd_val(inc) >= bcd_val(opp) + 7'd2));
`else
    win_hit = (bcd_val(inc) == WIN_VAL);
`endif

    case (state)
      IDLE, WIN: begin
        if (bus.start) begin
          state_nx   = PLAY;
          score_a_nx = 8'h00;
          score_b_nx = 8'h00;
          winner_nx  = 2'b00;
        end
      end
      PLAY: begin
        // prio_b set means A was granted last, so B wins a tie.
        if (bus.hit_a && (!bus.hit_b || !prio_b)) begin
          state_nx  = ADD;
          gnt_b_nx  = 1'b0;
          prio_b_nx = 1'b1;
          ack_a_nx  = 1'b1;
        end else if (bus.hit_b) begin
          state_nx  = ADD;
          gnt_b_nx  = 1'b1;
          prio_b_nx = 1'b0;
          ack_b_nx  = 1'b1;
        end
      end
      ADD: begin
        if (gnt_b)
          score_b_nx = inc;
        else
          score_a_nx = inc;
        if (win_hit) begin
          state_nx  = WIN;
          winner_nx = gnt_b ? 2'b10 : 2'b01;
        end else begin
          state_nx = PLAY;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.busy = (state == PLAY) || (state == ADD);
  assign bus.done = (state == WIN);

endmodule

// File: tb/tb_score_ctrl.sv
// Self-checking bench for score_ctrl: phase table plus a grant/score scoreboard
// fed by a decimal reference model, and hand-timed carry, reset and restart sequences.
module tb_score_ctrl;
`ifdef SCORE_CTRL_DEUCE_EN
  localparam int WIN = 3;
`else
  localparam int WIN = 21;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  score_ctrl_if bus();
  score_ctrl #(.WIN_SCORE(WIN)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic       pb;
    logic [7:0] sa;
    logic [7:0] sb;
    logic [1:0] win;
  } exp_t;

  typedef struct {
    logic       ha;
    logic       hb;
    logic       drop;
    int         grants;
    logic [7:0] sa;
    logic [7:0] sb;
    logic [1:0] win;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[8];
  int   n_pre, n_vec;
  int   passed = 0;
  int   total  = 0;

  int         ma, mb;
  logic       mptr_b;
  logic [1:0] mwin;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t, o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear(input logic clr_ptr);
    ma = 0;
    mb = 0;
    mwin = 2'b00;
    if (clr_ptr) mptr_b = 1'b0;
  endtask

  task automatic model_push(input logic ha, input logic hb, input int grants);
    for (int g = 0; g < grants; g++) begin
      logic pick, capped, won;
      int   mine, other;
      exp_t e;
      pick   = (ha && hb) ? mptr_b : hb;
      mptr_b = !pick;
      capped = 1'b0;
      if (pick) begin
        if (mb == 99) capped = 1'b1; else mb++;
        mine = mb; other = ma;
      end else begin
        if (ma == 99) capped = 1'b1; else ma++;
        mine = ma; other = mb;
      end
`ifdef SCORE_CTRL_DEUCE_EN
      won = capped || ((mine >= WIN) && (mine >= other + 2));
`else
      won = (mine == WIN);
`endif
      if (won) mwin = pick ? 2'b10 : 2'b01;
      e.pb = pick; e.sa = to_bcd(ma); e.sb = to_bcd(mb); e.win = mwin;
      exp_q.push_back(e);
    end
  endtask

  // Drives hits and consumes the scoreboard; starts and ends at posedge+1.
  task automatic run_hits(input logic ha, input logic hb, input int grants, input logic drop);
    int   got, cyc, budget;
    logic pending, saw;
    exp_t cur_e;
    got = 0; cyc = 0; pending = 1'b0; budget = grants * 4 + 10;
    cur_e = '{1'b0, 8'h00, 8'h00, 2'b00};
    bus.hit_a = ha;
    bus.hit_b = hb;
    while ((got < grants || pending) && cyc < budget) begin
      @(negedge clk);
      cyc++;
      saw = 1'b0;
      if (pending) begin
        check("sb_score_a", 32'(bus.score_a), 32'(cur_e.sa));
        check("sb_score_b", 32'(bus.score_b), 32'(cur_e.sb));
        check("sb_winner", 32'(bus.winner), 32'(cur_e.win));
        pending = 1'b0;
      end
      if (bus.ack_a || bus.ack_b) begin
        saw = 1'b1;
        got++;
        if (exp_q.size() == 0) begin
          check("unexpected_ack", 32'(exp_q.size()), 32'(1));
        end else begin
          cur_e = exp_q.pop_front();
          check("grant_b", 32'(bus.ack_b), 32'(cur_e.pb));
          check("grant_a", 32'(bus.ack_a), 32'(!cur_e.pb));
          pending = 1'b1;
        end
      end
      align();
      if (got >= grants || (saw && drop)) begin
        bus.hit_a = 1'b0;
        bus.hit_b = 1'b0;
      end else begin
        bus.hit_a = ha;
        bus.hit_b = hb;
      end
    end
    if (got < grants) check("timeout_grants", 32'(got), 32'(grants));
    if (pending) check("timeout_pending", 32'(pending), 32'(0));
    bus.hit_a = 1'b0;
    bus.hit_b = 1'b0;
  endtask

  task automatic apply_vec(input int i);
    model_push(vecs[i].ha, vecs[i].hb, vecs[i].grants);
    run_hits(vecs[i].ha, vecs[i].hb, vecs[i].grants, vecs[i].drop);
    @(negedge clk);
    check($sformatf("vec%0d_score_a", i), 32'(bus.score_a), 32'(vecs[i].sa));
    check($sformatf("vec%0d_score_b", i), 32'(bus.score_b), 32'(vecs[i].sb));
    check($sformatf("vec%0d_winner", i), 32'(bus.winner), 32'(vecs[i].win));
    check($sformatf("vec%0d_done", i), 32'(bus.done), 32'(vecs[i].win != 2'b00));
    align();
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    align();
    bus.start = 1'b0;
  endtask

  initial begin
    int   k;
    logic seen;
    bus.start = 1'b0;
    bus.hit_a = 1'b0;
    bus.hit_b = 1'b0;
    model_clear(1'b1);

`ifdef SCORE_CTRL_DEUCE_EN
    vecs[0] = '{1'b1, 1'b1, 1'b0, 4, 8'h02, 8'h02, 2'b00};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 2, 8'h02, 8'h00, 2'b00};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 2, 8'h02, 8'h02, 2'b00};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 1, 8'h03, 8'h02, 2'b00};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 1, 8'h03, 8'h03, 2'b00};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 1, 8'h04, 8'h03, 2'b00};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 1, 8'h05, 8'h03, 2'b01};
    n_pre = 1;
    n_vec = 7;
`else
    vecs[0] = '{1'b1, 1'b1, 1'b0, 4, 8'h02, 8'h02, 2'b00};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 7, 8'h02, 8'h09, 2'b00};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 21, 8'h21, 8'h00, 2'b01};
    n_pre = 2;
    n_vec = 3;
`endif

    #12;
    check("rst_score_a", 32'(bus.score_a), 32'(0));
    check("rst_score_b", 32'(bus.score_b), 32'(0));
    check("rst_winner", 32'(bus.winner), 32'(0));
    check("rst_flags", 32'({bus.busy, bus.done, bus.ack_a, bus.ack_b}), 32'(0));
    align();
    rst = 1'b1;

    bus.hit_a = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      seen = seen | bus.ack_a;
    end
    check("idle_hit_ignored", 32'(seen), 32'(0));
    check("idle_busy", 32'(bus.busy), 32'(0));
    bus.hit_a = 1'b0;
    align();

    pulse_start();
    @(negedge clk);
    check("start_busy", 32'(bus.busy), 32'(1));
    check("start_scores", 32'({bus.score_a, bus.score_b}), 32'(0));
    align();

    for (int i = 0; i < n_pre; i++) apply_vec(i);

`ifndef SCORE_CTRL_DEUCE_EN
    bus.hit_b = 1'b1;
    @(negedge clk);
    check("carry_t0_ack", 32'(bus.ack_b), 32'(0));
    check("carry_t0_score", 32'(bus.score_b), 32'(8'h09));
    align();
    @(negedge clk);
    check("carry_t1_ack", 32'(bus.ack_b), 32'(1));
    check("carry_t1_score", 32'(bus.score_b), 32'(8'h09));
    align();
    bus.hit_b = 1'b0;
    @(negedge clk);
    check("carry_t2_score", 32'(bus.score_b), 32'(8'h10));
    check("carry_t2_ack", 32'(bus.ack_b), 32'(0));
    align();
    mb = 10;
    mptr_b = 1'b0;
`endif

    bus.hit_a = 1'b1;
    k = 0;
    @(negedge clk);
    while (!bus.ack_a && k < 6) begin
      @(negedge clk);
      k++;
    end
    check("midadd_ack_seen", 32'(bus.ack_a), 32'(1));
    rst = 1'b0;
    #1;
    check("midadd_rst_ack", 32'({bus.ack_a, bus.ack_b}), 32'(0));
    check("midadd_rst_scores", 32'({bus.score_a, bus.score_b}), 32'(0));
    check("midadd_rst_busy", 32'(bus.busy), 32'(0));
    bus.hit_a = 1'b0;
    model_clear(1'b1);
    align();
    rst = 1'b1;
    pulse_start();
    @(negedge clk);
    check("rst_start_busy", 32'(bus.busy), 32'(1));
    check("rst_start_ack", 32'(bus.ack_a), 32'(0));
    align();

    for (int i = n_pre; i < n_vec; i++) apply_vec(i);

    @(negedge clk);
    check("win_busy", 32'(bus.busy), 32'(0));
    check("win_done", 32'(bus.done), 32'(1));
    align();

    bus.hit_a = 1'b1;
    bus.hit_b = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      seen = seen | bus.ack_a | bus.ack_b;
    end
    check("win_hits_ignored", 32'(seen), 32'(0));
    check("win_score_frozen", 32'({bus.score_a, bus.score_b}),
          32'({vecs[n_vec-1].sa, vecs[n_vec-1].sb}));
    bus.hit_a = 1'b0;
    bus.hit_b = 1'b0;
    align();

    pulse_start();
    model_clear(1'b0);
    @(negedge clk);
    check("restart_scores", 32'({bus.score_a, bus.score_b}), 32'(0));
    check("restart_winner", 32'(bus.winner), 32'(0));
    check("restart_flags", 32'({bus.busy, bus.done}), 32'(2'b10));
    align();

    model_push(1'b1, 1'b0, 1);
    run_hits(1'b1, 1'b0, 1, 1'b1);
    pulse_start();
    @(negedge clk);
    check("play_start_score_a", 32'(bus.score_a), 32'(8'h01));
    check("play_start_busy", 32'(bus.busy), 32'(1));
    check("play_start_winner", 32'(bus.winner), 32'(0));
    check("queue_drained", 32'(exp_q.size()), 32'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
